spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 16, frame length in bits (legal range 8..32).
REQ-002 The module SHALL have port clk, input, 1, system clock (40 MHz nominal); all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The module SHALL have port SS_n, input, 1, slave select from the master, active low, asynchronous to clk.
REQ-005 The module SHALL have port SCLK, input, 1, SPI clock from the master, asynchronous to clk.
REQ-006 The module SHALL have port MOSI, input, 1, serial data from the master, asynchronous to clk.
REQ-007 The module SHALL have port MISO, output, 1, serial data to the master.
REQ-008 The module SHALL have port tx_data, input, WIDTH, response word, captured at frame start.
REQ-009 The module SHALL have port rx_data, output, WIDTH, last complete received frame.
REQ-010 The module SHALL have port rdy, output, 1, one-cycle pulse marking that a complete frame is in rx_data.
REQ-011 The module SHALL have port busy, output, 1, high while a frame is in progress.

Function
REQ-012 The module SHALL support SPI mode 0 only: MSB first; the master samples on SCLK rise; data changes on SCLK fall.
REQ-013 The module SHALL pass SS_n, SCLK and MOSI each through a 2-flop synchronizer, then a third flop for edge detection.
REQ-014 The module SHALL support SCLK periods of at least 8 clk; behaviour at faster SCLK is undefined.
REQ-015 The module SHALL implement exactly two FSM states, IDLE and SHIFT.
REQ-016 IDLE -> SHIFT SHALL occur on a detected SS_n falling edge.
- Same cycle: load tx_data into shift register; clear bit counter to 0; assert busy.
REQ-017 In SHIFT, each detected SCLK rising edge SHALL:
- shift synchronized MOSI into the rx shift register LSB;
- increment the bit counter, saturating at WIDTH.
REQ-018 In SHIFT, each detected SCLK falling edge SHALL left-shift the tx shift register, but only while bit counter < WIDTH.
REQ-019 MISO SHALL equal the tx shift register MSB while in SHIFT, and 0 in IDLE.
REQ-020 SHIFT -> IDLE SHALL occur on a detected SS_n rising edge; busy deasserts on that same edge.
REQ-021 On SS_n rise with bit counter == WIDTH, the module SHALL:
- copy the rx shift register to rx_data on the same edge;
- pulse rdy high for exactly one clk, in the following cycle.
REQ-022 On SS_n rise with bit counter < WIDTH (aborted frame), the module SHALL leave rx_data unchanged and not pulse rdy.
REQ-023 SCLK edges beyond WIDTH in one frame SHALL be ignored: no counter wrap, rx register frozen, MISO held at 0.
REQ-024 SCLK edges detected in IDLE SHALL have no effect.
REQ-025 If the SS_n falling edge and an SCLK edge are detected in the same cycle, the SS_n edge SHALL take priority and the SCLK edge SHALL be discarded.
REQ-026 A new SS_n fall in the cycle right after an SS_n rise SHALL start a new frame normally; rdy for the previous frame SHALL still pulse.
REQ-027 tx_data changes during SHIFT SHALL NOT affect the frame in progress.

Reset
REQ-028 While rst is high, the module SHALL force state IDLE, MISO=0, rdy=0, busy=0, rx_data=0, counter=0, and both shift registers to 0.
REQ-029 While rst is high, the module SHALL preset the synchronizer flops to SS_n=1, SCLK=0, MOSI=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no rdy; after release, the module SHALL wait for a fresh SS_n fall, so a still-low SS_n starts no frame.

Verification
REQ-031 Scenario: WIDTH=16, tx_data=16'hA55A, master sends 16'h3C81 at SCLK=clk/16 -> MISO bits read 16'hA55A, rx_data=16'h3C81, exactly one rdy pulse 1 clk after synchronized SS_n rise.
REQ-032 Scenario: 9 SCLK pulses, then SS_n rises -> no rdy, rx_data keeps its prior value, busy low after the SS_n rise.
REQ-033 Scenario: 20 SCLK pulses with 16'hFFFF on MOSI in the first 16 bits, then MOSI=0 -> rx_data=16'hFFFF, MISO=0 after bit 16, one rdy.
REQ-034 Scenario: rst pulsed high at bit 7; SS_n stays low and 9 more SCLK pulses follow -> no rdy, MISO=0, busy=0 until the next SS_n fall.
REQ-035 Scenario: back-to-back frames 16'h1234 and 16'hBEEF with SS_n high for 4 clk -> two rdy pulses, rx_data 16'h1234 then 16'hBEEF.
REQ-036 Scenario: SCLK toggled with SS_n high -> busy, rdy and MISO all remain 0.

Source files
------------

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave
// Brief   : SPI mode-0 slave with synchronized inputs, full-duplex WIDTH-bit
//           frames, rdy pulse on completed frames and abort on short frames.
// Revision: 1.0 - initial release
// ============================================================================
module spi_slave #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rdy,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WIDTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  // [0] first sync flop, [1] synchronized value, [2] previous value for edges
  logic [2:0]       ss_q, sclk_q, mosi_q;
  logic [1:0]       settle_q;
  logic             armed_q;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q     <= 3'b111;
      sclk_q   <= 3'b000;
      mosi_q   <= 3'b000;
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      ss_q     <= {ss_q[1:0], SS_n};
      sclk_q   <= {sclk_q[1:0], SCLK};
      mosi_q   <= {mosi_q[1:0], MOSI};
      settle_q <= {settle_q[0], 1'b1};
      // A frame may only start once SS_n has genuinely been seen high after
      // reset, so a select line held low through reset cannot fake a fall.
      armed_q  <= armed_q | (settle_q[1] & ss_q[1]);
    end
  end

  assign ss_fall   = armed_q & ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    cnt_d     = cnt_q;
    rdy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = SHIFT;
          tx_sr_d = tx_data;
          rx_sr_d = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) begin
            rx_data_d = rx_sr_q;
            rdy_d     = 1'b1;
          end
        end else if (sclk_rise) begin
          if (cnt_q < CNT_FULL) begin
            rx_sr_d = {rx_sr_q[WIDTH-2:0], mosi_q[2]};
            cnt_d   = cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          // Once the last bit has been sampled the word is spent: MISO drops
          // to 0 and stays there for any surplus SCLK edges.
          if (cnt_q < CNT_FULL) begin
            tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
          end else begin
            tx_sr_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO    = (state_q == SHIFT) & tx_sr_q[WIDTH-1];
  assign busy    = (state_q == SHIFT);
  assign rdy     = rdy_q;
  assign rx_data = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave
// Brief   : Randomized scoreboard bench for spi_slave (WIDTH=16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_slave;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         SS_n;
  logic         SCLK;
  logic         MOSI;
  logic         MISO;
  logic [W-1:0] tx_data;
  logic [W-1:0] rx_data;
  logic         rdy;
  logic         busy;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           rise_cyc = 0;
  int           rdy_seen = 0;
  int           rdy_exp = 0;
  logic [W-1:0] last_rx = '0;
  logic [W-1:0] exp_q[$];

  spi_slave #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .rdy     (rdy),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rdy pulse must match the oldest pending expected frame.
  initial begin
    forever begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        rdy_seen++;
        check("rdy_latency", cyc - rise_cyc, 3);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rdy: rx_data %h with no frame pending", rx_data);
        end else begin
          check("rx_data", rx_data, exp_q.pop_front());
        end
        @(negedge clk);
        check("rdy_width", rdy, 0);
      end
    end
  end

  // One master transaction: npulse SCLK pulses at half-period hp clk, MOSI bits
  // taken MSB-first from mosi_bits. rst_at >= 0 pulses reset before that pulse.
  task automatic frame(input logic [W-1:0] txw, input logic [31:0] mosi_bits,
                       input int npulse, input int hp, input int gap, input int rst_at);
    logic [W-1:0] exp_rx;
    logic [W-1:0] obs_miso;
    logic [W-1:0] exp_miso;
    bit           was_reset;
    int           nb;
    exp_rx    = '0;
    obs_miso  = '0;
    was_reset = 1'b0;
    tx_data   = txw;
    SS_n      = 1'b0;
    MOSI      = mosi_bits[31];
    repeat (hp + 2) @(negedge clk);
    tx_data = W'($urandom);
    check("busy_in_frame", busy, 1);
    for (int i = 0; i < npulse; i++) begin
      MOSI = mosi_bits[31 - i];
      if (i > 0) repeat (hp) @(negedge clk);
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        was_reset = 1'b1;
        last_rx   = '0;
        repeat (2) @(negedge clk);
      end
      if (was_reset) begin
        check("miso_after_reset", MISO, 0);
        check("busy_after_reset", busy, 0);
      end else if (i < W) begin
        obs_miso = {obs_miso[W-2:0], MISO};
        exp_rx   = {exp_rx[W-2:0], mosi_bits[31 - i]};
      end else begin
        check("miso_past_width", MISO, 0);
      end
      SCLK = 1'b1;
      repeat (hp) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (hp) @(negedge clk);
    if (!was_reset) begin
      nb = (npulse < W) ? npulse : W;
      exp_miso = (nb == 0) ? '0 : (txw >> (W - nb));
      check("miso_word", obs_miso, exp_miso);
      if (npulse >= W) begin
        exp_q.push_back(exp_rx);
        last_rx = exp_rx;
        rdy_exp++;
      end
    end
    SS_n     = 1'b1;
    rise_cyc = cyc;
    repeat (gap) @(negedge clk);
    if (gap >= 5) begin
      check("busy_after_frame", busy, 0);
      check("rx_data_hold", rx_data, last_rx);
    end
  endtask

  initial begin
    rst     = 1'b1;
    SS_n    = 1'b1;
    SCLK    = 1'b0;
    MOSI    = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 0);
    check("reset_rdy", rdy, 0);
    check("reset_busy", busy, 0);
    check("reset_miso", MISO, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Directed scenarios
    frame(16'hA55A, 32'h3C81_0000, 16, 8, 8, -1);
    frame(16'h5A5A, 32'hFFFF_0000, 9, 8, 8, -1);
    frame(16'hC3C3, 32'hFFFF_0000, 20, 6, 8, -1);
    frame(16'h0F0F, 32'h1234_0000, 16, 8, 4, -1);
    frame(16'hF00D, 32'hBEEF_0000, 16, 8, 8, -1);
    frame(16'h9999, 32'h5555_0000, 16, 5, 10, 7);
    check("rx_after_reset", rx_data, 0);

    // SCLK activity with SS_n high is ignored
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_miso", MISO, 0);
      SCLK = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_rdy", rdy, 0);
    end

    // Randomized frames, including 1-clk SS_n-high gaps
    for (int f = 0; f < 14; f++) begin
      int np;
      np = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15))
                                       : int'($urandom_range(16, 22));
      frame(W'($urandom), $urandom, np, int'($urandom_range(4, 8)),
            int'($urandom_range(1, 8)), -1);
    end

    repeat (12) @(negedge clk);
    check("pending_frames", exp_q.size(), 0);
    check("rdy_count", rdy_seen, rdy_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
